// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// codes, FSM state type and a two's-complement magnitude helper.
package mult_div_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Working width of the magnitude helper; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int ABS_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Absolute value of a two's-complement number whose sign is passed
  // separately. The low bits of a negation depend only on the low bits of
  // the operand, so zero-extension by the caller is harmless.
  function automatic logic [ABS_W-1:0] twos_abs(input logic [ABS_W-1:0] value,
                                                input logic             neg);
    return neg ? -value : value;
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// mdu_sign_fix: combinational sign restoration of the unsigned hi/lo
// produced by the iterative core. Multiply negates the full 2*WIDTH
// product; divide negates the quotient on differing signs and gives the
// remainder the dividend's sign.
module mdu_sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [2*WIDTH-1:0] prod;

  // Apply result signs to the raw magnitudes.
  always_comb begin
    prod   = {raw_hi, raw_lo};
    fix_hi = raw_hi;
    fix_lo = raw_lo;
    if (op == OP_MULT) begin
      if (sign_a ^ sign_b) begin
        prod   = -prod;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
      end
    end else begin
      if (sign_a ^ sign_b) fix_lo = -raw_lo;
      if (sign_a)          fix_hi = -raw_hi;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply / restoring divide with hi/lo
// result registers and a start/busy/done handshake.
// Optional build macro MULT_DIV_EARLY_OUT_EN: multiply finishes as soon as
// the remaining multiplier bits are zero (variable latency, same result).
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic               sign_a, sign_b;
  logic               dz_q;

  // Multiply: acc = product, opnd = multiplicand shifted left each step,
  // mplier = multiplier shifted right each step.
  // Divide:   acc = {remainder, dividend->quotient}, opnd[WIDTH-1:0] = divisor.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] opnd;
  logic [WIDTH-1:0]   mplier;

  logic               in_sign_a, in_sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_zero_req;

  logic [2*WIDTH-1:0] add_sum;
  logic [2*WIDTH-1:0] acc_mul_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] acc_div_nxt;
  logic               last_iter;
  logic               calc_done;

  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign in_sign_a    = is_signed & a[WIDTH-1];
  assign in_sign_b    = is_signed & b[WIDTH-1];
  assign mag_a        = WIDTH'(twos_abs(ABS_W'(a), in_sign_a));
  assign mag_b        = WIDTH'(twos_abs(ABS_W'(b), in_sign_b));
  assign div_zero_req = (op == OP_DIV) && (b == '0);

  // One multiply step: conditionally add the shifted multiplicand.
  always_comb begin
    add_sum     = acc + opnd;
    acc_mul_nxt = mplier[0] ? add_sum : acc;
  end

  // One restoring-division step: shift in the next dividend bit and keep
  // the trial difference only when it is non-negative.
  always_comb begin
    rem_sh      = acc[2*WIDTH-1:WIDTH-1];
    diff        = {1'b0, rem_sh} - {2'b0, opnd[WIDTH-1:0]};
    q_bit       = ~diff[WIDTH+1];
    rem_new     = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    acc_div_nxt = {rem_new, acc[WIDTH-2:0], q_bit};
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_DIV_EARLY_OUT_EN
  assign calc_done = last_iter || ((op_q == OP_MULT) && (mplier[WIDTH-1:1] == '0));
`else
  assign calc_done = last_iter;
`endif

  mdu_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .op     (op_q),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .raw_hi (acc[2*WIDTH-1:WIDTH]),
    .raw_lo (acc[WIDTH-1:0]),
    .fix_hi (fix_hi),
    .fix_lo (fix_lo)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic; divide by zero bypasses the iteration phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = div_zero_req ? FINISH : CALC;
      end
      CALC: begin
        if (calc_done) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, handshake and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      op_q        <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz_q        <= 1'b0;
      acc         <= '0;
      opnd        <= '0;
      mplier      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            op_q        <= op;
            sign_a      <= in_sign_a;
            sign_b      <= in_sign_b;
            dz_q        <= div_zero_req;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (op == OP_MULT) begin
              acc    <= '0;
              opnd   <= {{WIDTH{1'b0}}, mag_a};
              mplier <= mag_b;
            end else begin
              acc    <= {{WIDTH{1'b0}}, mag_a};
              opnd   <= {{WIDTH{1'b0}}, mag_b};
              mplier <= '0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q == OP_MULT) begin
            acc    <= acc_mul_nxt;
            opnd   <= opnd << 1;
            mplier <= mplier >> 1;
          end else begin
            acc <= acc_div_nxt;
          end
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (dz_q) begin
            div_by_zero <= 1'b1;
          end else begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
